// File: rtl/out_keep_stage.sv
// Two-entry registered skid buffer between the DNN engine output stream and the DMA.
// Clips tkeep to the bytes-per-transfer count and tracks per-packet bpt consistency.
module out_keep_stage #(
  parameter int AXI_WIDTH = 128,
  parameter int W_BPT     = 5,
  parameter int CNT_BITS  = 16
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  input  logic [AXI_WIDTH-1:0]   s_axis_tdata,
  input  logic [AXI_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [W_BPT-1:0]       s_bytes_per_transfer,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic [AXI_WIDTH-1:0]   m_axis_tdata,
  output logic [AXI_WIDTH/8-1:0] m_axis_tkeep,
  output logic [CNT_BITS-1:0]    beat_count,
  output logic [CNT_BITS-1:0]    pkt_count,
  output logic                   bpt_err
);
  localparam int NB = AXI_WIDTH / 8;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  typedef struct packed {
    logic [AXI_WIDTH-1:0] data;
    logic [NB-1:0]        keep;
    logic                 last;
  } beat_t;

  logic [1:0]          state_q, state_d;
  beat_t               head_q, head_d, skid_q, skid_d;
  logic                tvalid_q, tvalid_d, tready_q, tready_d;
  logic [CNT_BITS-1:0] beat_cnt_q, beat_cnt_d, pkt_cnt_q, pkt_cnt_d;
  logic                err_q, err_d, first_q, first_d;
  logic [W_BPT-1:0]    bpt_lat_q, bpt_lat_d;

  logic [31:0] bpt_ext;
  logic [NB-1:0] mask;
  beat_t in_beat;
  logic in_acc, out_acc;

  assign bpt_ext = 32'(s_bytes_per_transfer);

  // Out-of-range bpt (0 or wider than the bus) means "no clipping".
  always_comb begin
    mask = '0;
    for (int i = 0; i < NB; i++)
      mask[i] = (bpt_ext == 32'd0 || bpt_ext > 32'(NB)) ? 1'b1 : (32'(i) < bpt_ext);
  end

  assign in_beat = '{data: s_axis_tdata, keep: s_axis_tkeep & mask, last: s_axis_tlast};
  assign in_acc  = s_axis_tvalid & tready_q;
  assign out_acc = tvalid_q & m_axis_tready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: if (in_acc) begin head_d = in_beat; state_d = ST_ONE; end
      ST_ONE: begin
        if (in_acc && out_acc) head_d = in_beat;
        else if (in_acc) begin skid_d = in_beat; state_d = ST_TWO; end
        else if (out_acc) state_d = ST_EMPTY;
      end
      ST_TWO: if (out_acc) begin head_d = skid_q; state_d = ST_ONE; end
      default: state_d = ST_EMPTY;
    endcase
    // Handshake outputs are registered copies of the next-state decode.
    tvalid_d = (state_d != ST_EMPTY);
    tready_d = (state_d != ST_TWO);
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    if (out_acc) begin
      if (head_q.last) begin
        beat_cnt_d = '0;
        pkt_cnt_d  = pkt_cnt_q + 1'b1;
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end
  end

  // First beat of a packet latches bpt; later beats are compared against it.
  always_comb begin
    err_d     = err_q;
    first_d   = first_q;
    bpt_lat_d = bpt_lat_q;
    if (in_acc) begin
      if (first_q) bpt_lat_d = s_bytes_per_transfer;
      else if (s_bytes_per_transfer != bpt_lat_q) err_d = 1'b1;
      first_d = s_axis_tlast;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      tvalid_q   <= 1'b0;
      tready_q   <= 1'b0;
      beat_cnt_q <= '0;
      pkt_cnt_q  <= '0;
      err_q      <= 1'b0;
      first_q    <= 1'b1;
      bpt_lat_q  <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      tvalid_q   <= tvalid_d;
      tready_q   <= tready_d;
      beat_cnt_q <= beat_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_q      <= err_d;
      first_q    <= first_d;
      bpt_lat_q  <= bpt_lat_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = head_q.last;
  assign m_axis_tdata  = head_q.data;
  assign m_axis_tkeep  = head_q.keep;
  assign beat_count    = beat_cnt_q;
  assign pkt_count     = pkt_cnt_q;
  assign bpt_err       = err_q;
endmodule

// File: tb/tb_out_keep_stage.sv
// Bench for out_keep_stage: queue-based stream model checked every cycle, plus literal pins.
module tb_out_keep_stage;
  localparam int AW = 128;
  localparam int NB = 16;
  localparam int WB = 5;
  localparam int CB = 16;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [AW-1:0] s_axis_tdata;
  logic [NB-1:0] s_axis_tkeep;
  logic [WB-1:0] s_bytes_per_transfer;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [AW-1:0] m_axis_tdata;
  logic [NB-1:0] m_axis_tkeep;
  logic [CB-1:0] beat_count, pkt_count;
  logic          bpt_err;

  out_keep_stage #(.AXI_WIDTH(AW), .W_BPT(WB), .CNT_BITS(CB)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_bytes_per_transfer(s_bytes_per_transfer),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .beat_count(beat_count), .pkt_count(pkt_count), .bpt_err(bpt_err)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [AW-1:0] d;
    logic [NB-1:0] k;
    logic          l;
  } exp_t;

  exp_t          q[$];
  int            nvec = 0;
  int            nerr = 0;
  int            n_in = 0;
  int            rmode = 0;
  logic [CB-1:0] m_beat, m_pkt;
  logic          m_err, m_first, m_up;
  logic [WB-1:0] m_lat;

  function automatic logic [NB-1:0] mask_of(input int bpt);
    logic [16:0] t;
    if (bpt == 0 || bpt > NB) return '1;
    t = (17'd1 << bpt) - 17'd1;
    return t[NB-1:0];
  endfunction

  task automatic chk(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: accepted beats sit in a queue until the downstream takes them.
  always @(negedge aclk) begin : model
    exp_t h;
    logic ia, oa;
    if (!aresetn) begin
      q.delete();
      m_beat = '0; m_pkt = '0; m_err = 1'b0; m_first = 1'b1; m_up = 1'b0;
      chk("rst_tvalid", AW'(m_axis_tvalid), '0);
      chk("rst_tready", AW'(s_axis_tready), '0);
      chk("rst_tlast",  AW'(m_axis_tlast), '0);
      chk("rst_tdata",  m_axis_tdata, '0);
      chk("rst_tkeep",  AW'(m_axis_tkeep), '0);
      chk("rst_beat",   AW'(beat_count), '0);
      chk("rst_pkt",    AW'(pkt_count), '0);
      chk("rst_err",    AW'(bpt_err), '0);
    end else begin
      chk("tready", AW'(s_axis_tready), AW'(m_up && q.size() < 2));
      chk("tvalid", AW'(m_axis_tvalid), AW'(q.size() > 0));
      if (q.size() > 0) begin
        chk("tdata", m_axis_tdata, q[0].d);
        chk("tkeep", AW'(m_axis_tkeep), AW'(q[0].k));
        chk("tlast", AW'(m_axis_tlast), AW'(q[0].l));
      end
      chk("beat_count", AW'(beat_count), AW'(m_beat));
      chk("pkt_count",  AW'(pkt_count), AW'(m_pkt));
      chk("bpt_err",    AW'(bpt_err), AW'(m_err));
      ia = s_axis_tvalid && m_up && q.size() < 2;
      oa = q.size() > 0 && m_axis_tready;
      if (oa) begin
        h = q.pop_front();
        if (h.l) begin m_pkt++; m_beat = '0; end
        else m_beat++;
      end
      if (ia) begin
        q.push_back('{s_axis_tdata, s_axis_tkeep & mask_of(int'(s_bytes_per_transfer)), s_axis_tlast});
        n_in++;
        if (m_first) m_lat = s_bytes_per_transfer;
        else if (s_bytes_per_transfer != m_lat) m_err = 1'b1;
        m_first = s_axis_tlast;
      end
      m_up = 1'b1;
    end
  end

  always @(posedge aclk) begin
    #2;
    case (rmode)
      0: m_axis_tready = 1'b1;
      1: m_axis_tready = 1'($urandom_range(0, 1));
      default: m_axis_tready = 1'b0;
    endcase
  end

  task automatic drive(input int bpt, input logic last, input logic [NB-1:0] keep);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = {$urandom, $urandom, $urandom, $urandom};
    s_axis_tkeep  = keep;
    s_axis_tlast  = last;
    s_bytes_per_transfer = WB'(bpt);
  endtask

  task automatic wait_acc();
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge aclk);
      acc = s_axis_tready;
      @(posedge aclk); #1;
    end
    if (!acc) begin
      nvec++; nerr++;
      $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send(input int bpt, input logic last, input logic [NB-1:0] keep);
    drive(bpt, last, keep);
    wait_acc();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int base, nl, pbpt, bpt;
    logic last;
    aresetn = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0;
    s_axis_tlast = 1'b0; s_bytes_per_transfer = '0; m_axis_tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    #1 chk("tready_after_deassert", AW'(s_axis_tready), AW'(0));
    @(posedge aclk); #1;
    chk("tready_one_cycle_later", AW'(s_axis_tready), AW'(1));

    // 8-beat full-width packet, downstream always ready
    for (int i = 0; i < 8; i++) send(16, i == 7, 16'hFFFF);
    idle(3);
    @(negedge aclk);
    chk("stream_pkt_count", AW'(pkt_count), AW'(1));
    chk("stream_beat_count", AW'(beat_count), AW'(0));
    @(posedge aclk); #1;

    // keep clipping, held at the output by a stalled downstream
    rmode = 2;
    send(6, 1'b1, 16'hFFFF);
    @(negedge aclk); chk("keep_bpt6", AW'(m_axis_tkeep), AW'(16'h003F));
    @(posedge aclk); #1; rmode = 0; idle(2); rmode = 2;
    send(0, 1'b1, 16'hFFFF);
    @(negedge aclk); chk("keep_bpt0", AW'(m_axis_tkeep), AW'(16'hFFFF));
    @(posedge aclk); #1; rmode = 0; idle(2); rmode = 2;
    send(20, 1'b1, 16'hFFFF);
    @(negedge aclk); chk("keep_bpt20", AW'(m_axis_tkeep), AW'(16'hFFFF));
    @(posedge aclk); #1; rmode = 0; idle(2); rmode = 2;
    send(6, 1'b1, 16'hF0F0);
    @(negedge aclk); chk("keep_bpt6_sparse", AW'(m_axis_tkeep), AW'(16'h0030));
    @(posedge aclk); #1; rmode = 0; idle(2);

    // downstream stall: only two beats get in
    rmode = 2; base = n_in;
    send(16, 1'b0, 16'hFFFF);
    send(16, 1'b0, 16'hFFFF);
    drive(16, 1'b0, 16'hFFFF);
    idle(5);
    @(negedge aclk);
    chk("stall_accepted", AW'(n_in - base), AW'(2));
    chk("stall_tready", AW'(s_axis_tready), AW'(0));
    @(posedge aclk); #1;
    rmode = 0;
    wait_acc();
    send(16, 1'b1, 16'hFFFF);
    idle(4);

    // bpt mismatch inside a packet, then a clean packet
    @(negedge aclk); chk("err_before", AW'(bpt_err), AW'(0));
    @(posedge aclk); #1;
    send(16, 1'b0, 16'hFFFF); send(16, 1'b0, 16'hFFFF);
    send(8, 1'b0, 16'hFFFF);  send(16, 1'b1, 16'hFFFF);
    idle(3);
    @(negedge aclk); chk("err_set", AW'(bpt_err), AW'(1));
    @(posedge aclk); #1;
    send(12, 1'b0, 16'hFFFF); send(12, 1'b1, 16'hFFFF);
    idle(3);
    @(negedge aclk); chk("err_sticky", AW'(bpt_err), AW'(1));
    @(posedge aclk); #1;

    // reset with both entries occupied
    rmode = 2;
    send(16, 1'b0, 16'hFFFF); send(16, 1'b0, 16'hFFFF);
    aresetn = 1'b0;
    #1;
    chk("areset_tvalid", AW'(m_axis_tvalid), AW'(0));
    chk("areset_pkt", AW'(pkt_count), AW'(0));
    chk("areset_err", AW'(bpt_err), AW'(0));
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk); #1; rmode = 0;
    send(16, 1'b0, 16'hFFFF);
    @(negedge aclk); chk("fresh_beat_count", AW'(beat_count), AW'(0));
    @(posedge aclk); #1;
    send(16, 1'b0, 16'hFFFF); send(16, 1'b1, 16'hFFFF);
    idle(3);
    @(negedge aclk);
    chk("fresh_pkt_count", AW'(pkt_count), AW'(1));
    chk("fresh_beat_end", AW'(beat_count), AW'(0));
    @(posedge aclk); #1;

    // random traffic with random downstream backpressure
    rmode = 1; nl = 0; pbpt = $urandom_range(0, 20);
    for (int i = 0; i < 1000; i++) begin
      bpt  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 20)) : pbpt;
      last = (i == 999) || ($urandom_range(0, 5) == 0);
      send(bpt, last, NB'($urandom));
      if (last) begin nl++; pbpt = $urandom_range(0, 20); end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    rmode = 0;
    idle(5);
    @(negedge aclk);
    chk("rand_pkt_count", AW'(pkt_count), AW'(CB'(1 + nl)));
    chk("rand_drained", AW'(m_axis_tvalid), AW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
